// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/MEM hazard inputs and the
// stall/flush/MDU control outputs. The pipeline side is the master.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_branch;
    logic             id_redirect;
    logic             id_mdu_start;
    logic             id_mdu_read;
    logic             ex_regw;
    logic             ex_mem2r;
    logic [4:0]       ex_rd;
    logic             mem_mem2r;
    logic [4:0]       mem_rd;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             mdu_start;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_redirect,
               id_mdu_start, id_mdu_read, ex_regw, ex_mem2r, ex_rd,
               mem_mem2r, mem_rd,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
               mdu_start, mdu_busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_redirect,
               id_mdu_start, id_mdu_read, ex_regw, ex_mem2r, ex_rd,
               mem_mem2r, mem_rd,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
               mdu_start, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use and ID-branch operand
// stalls, MDU busy sequencing, IF flush on redirect, and a saturating
// stall-cycle counter. Forwarding selection lives elsewhere.
// Every output is forced to 0 while rst is high.
module hazard_ctrl #(
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hif
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LAT_M1 = 8'(MDU_LAT - 1);

    state_t           state, state_next;
    logic [7:0]       busy_cnt, busy_cnt_next;
    logic [CNT_W-1:0] cnt;
    logic             ex_hit, mem_hit;
    logic             lu, br, md, stall, start;

    // Operand-match terms: ID reads a register that EX/MEM will write; $0 never matches.
    always_comb begin
        ex_hit  = (hif.ex_rd != 5'd0) &&
                  ((hif.ex_rd == hif.id_rs && hif.id_use_rs) ||
                   (hif.ex_rd == hif.id_rt && hif.id_use_rt));
        mem_hit = (hif.mem_rd != 5'd0) &&
                  ((hif.mem_rd == hif.id_rs && hif.id_use_rs) ||
                   (hif.mem_rd == hif.id_rt && hif.id_use_rt));
    end

    // Hazard terms; a branch behind a load stalls twice (lu, then the MEM-load term).
    always_comb begin
        lu    = hif.ex_mem2r && ex_hit;
        br    = hif.id_branch && ((hif.ex_regw && ex_hit) || (hif.mem_mem2r && mem_hit));
        md    = (state == BUSY) && (hif.id_mdu_read || hif.id_mdu_start);
        stall = lu || br || md;
        start = hif.id_mdu_start && !stall;
    end

    // MDU FSM next state: a start loads MDU_LAT-1, BUSY counts down to 0.
    always_comb begin
        state_next    = state;
        busy_cnt_next = busy_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = BUSY;
                    busy_cnt_next = LAT_M1;
                end
            end
            BUSY: begin
                if (busy_cnt == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    busy_cnt_next = busy_cnt - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // MDU state register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            busy_cnt <= busy_cnt_next;
        end
    end

    // Stall-cycle counter, saturating at all-ones; flush-only cycles do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Output drive; stall outranks flush and start, a redirect with a start does both.
    always_comb begin
        hif.pc_stall     = !rst && stall;
        hif.if_id_stall  = !rst && stall;
        hif.id_ex_bubble = !rst && stall;
        hif.if_id_flush  = !rst && hif.id_redirect && !stall;
        hif.mdu_start    = !rst && start;
        hif.mdu_busy     = !rst && (state == BUSY);
        hif.stall_cnt    = rst ? '0 : cnt;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model and
// per-cycle output comparison, plus literal expectations per scenario.
module tb_hazard_ctrl;
    localparam int MDU_LAT = 8;
    localparam int CNT_W   = 4;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int     m_busy_left = 0;   // MDU cycles still to run
    longint m_cnt = 0;         // stall cycles seen

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((r == hif.id_rs && hif.id_use_rs) || (r == hif.id_rt && hif.id_use_rt));
    endfunction

    function automatic bit e_busy();
        return !rst && (m_busy_left > 0);
    endfunction

    function automatic bit e_stall();
        bit load_use, branch_op, mdu_wait;
        load_use  = hif.ex_mem2r && reads(hif.ex_rd);
        branch_op = hif.id_branch && ((hif.ex_regw && reads(hif.ex_rd)) || (hif.mem_mem2r && reads(hif.mem_rd)));
        mdu_wait  = (m_busy_left > 0) && (hif.id_mdu_read || hif.id_mdu_start);
        return !rst && (load_use || branch_op || mdu_wait);
    endfunction

    function automatic bit e_flush();
        return !rst && hif.id_redirect && !e_stall();
    endfunction

    function automatic bit e_start();
        return !rst && hif.id_mdu_start && !e_stall();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy_left <= 0;
            m_cnt       <= 0;
        end else begin
            if (e_stall()) m_cnt <= (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
            if (e_start()) m_busy_left <= MDU_LAT;
            else if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pc_stall",     hif.pc_stall,     e_stall());
            chk("m_if_id_stall",  hif.if_id_stall,  e_stall());
            chk("m_id_ex_bubble", hif.id_ex_bubble, e_stall());
            chk("m_if_id_flush",  hif.if_id_flush,  e_flush());
            chk("m_mdu_start",    hif.mdu_start,    e_start());
            chk("m_mdu_busy",     hif.mdu_busy,     e_busy());
            chk("m_stall_cnt",    hif.stall_cnt,    rst ? 0 : m_cnt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.id_rs = 5'd0; hif.id_rt = 5'd0;
        hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0;
        hif.id_branch = 1'b0; hif.id_redirect = 1'b0;
        hif.id_mdu_start = 1'b0; hif.id_mdu_read = 1'b0;
        hif.ex_regw = 1'b0; hif.ex_mem2r = 1'b0; hif.ex_rd = 5'd0;
        hif.mem_mem2r = 1'b0; hif.mem_rd = 5'd0;
    endtask

    task automatic id_reads(input logic [4:0] rs, input logic [4:0] rt);
        hif.id_rs = rs; hif.id_rt = rt;
        hif.id_use_rs = 1'b1; hif.id_use_rt = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        clear_inputs();
        cmp_en = 1'b1;
        // reset: a live load-use must not show while rst is high
        rst = 1'b1;
        hif.ex_mem2r = 1'b1; hif.ex_regw = 1'b1; hif.ex_rd = 5'd2; id_reads(5'd2, 5'd4);
        #1 chk("rst_pc_stall", hif.pc_stall, 0);
        tick();
        chk("rst_stall_cnt", hif.stall_cnt, 0);
        do_reset();

        // 1: lw $2 ; add $3,$2,$4 -> one stall
        hif.ex_mem2r = 1'b1; hif.ex_regw = 1'b1; hif.ex_rd = 5'd2; id_reads(5'd2, 5'd4);
        #1 chk("t1_stall", hif.pc_stall, 1);
        tick();
        clear_inputs(); hif.mem_mem2r = 1'b1; hif.mem_rd = 5'd2; id_reads(5'd2, 5'd4);
        #1 chk("t1_release", hif.pc_stall, 0);
        chk("t1_cnt", hif.stall_cnt, 1);
        tick();

        // 2a: add $5 ; beq $5,$6 -> one stall
        clear_inputs(); hif.ex_regw = 1'b1; hif.ex_rd = 5'd5; id_reads(5'd5, 5'd6); hif.id_branch = 1'b1;
        #1 chk("t2a_stall", hif.if_id_stall, 1);
        tick();
        clear_inputs(); hif.mem_rd = 5'd5; id_reads(5'd5, 5'd6); hif.id_branch = 1'b1;
        #1 chk("t2a_release", hif.if_id_stall, 0);
        chk("t2a_cnt", hif.stall_cnt, 2);
        tick();

        // 2b/3: lw $5 ; taken beq $5 -> two stalls with flush held, then flush
        clear_inputs(); hif.ex_mem2r = 1'b1; hif.ex_regw = 1'b1; hif.ex_rd = 5'd5;
        id_reads(5'd5, 5'd6); hif.id_branch = 1'b1; hif.id_redirect = 1'b1;
        #1 chk("t2b_stall1", hif.id_ex_bubble, 1);
        chk("t2b_noflush1", hif.if_id_flush, 0);
        tick();
        clear_inputs(); hif.mem_mem2r = 1'b1; hif.mem_rd = 5'd5;
        id_reads(5'd5, 5'd6); hif.id_branch = 1'b1; hif.id_redirect = 1'b1;
        #1 chk("t2b_stall2", hif.id_ex_bubble, 1);
        chk("t2b_noflush2", hif.if_id_flush, 0);
        tick();
        clear_inputs(); id_reads(5'd5, 5'd6); hif.id_branch = 1'b1; hif.id_redirect = 1'b1;
        #1 chk("t2b_flush", hif.if_id_flush, 1);
        chk("t2b_nostall", hif.pc_stall, 0);
        chk("t2b_cnt", hif.stall_cnt, 4);
        tick();

        // 3: taken j, no hazard
        clear_inputs(); hif.id_redirect = 1'b1;
        #1 chk("t3_flush", hif.if_id_flush, 1);
        tick();
        clear_inputs();
        #1 chk("t3_flush_off", hif.if_id_flush, 0);
        tick();

        // 4: mult ; mflo -> busy 8 cycles, mflo stalled 8 cycles
        do_reset();
        hif.id_mdu_start = 1'b1;
        #1 chk("t4_start", hif.mdu_start, 1);
        tick();
        clear_inputs(); hif.id_mdu_read = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && hif.mdu_busy; i++) begin
            if (hif.pc_stall) n++;
            tick();
        end
        chk("t4_mflo_stalls", n, 8);
        chk("t4_idle", hif.mdu_busy, 0);
        chk("t4_mflo_go", hif.pc_stall, 0);
        tick();

        // 4b: back-to-back mult stalls until IDLE, then issues
        clear_inputs(); hif.id_mdu_start = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 20 && hif.mdu_busy; i++) begin
            if (hif.pc_stall && !hif.mdu_start) n++;
            tick();
        end
        chk("t4b_stalls", n, 8);
        chk("t4b_issue", hif.mdu_start, 1);
        tick();
        clear_inputs();
        for (int i = 0; i < 20 && hif.mdu_busy; i++) tick();
        chk("t4b_drain", hif.mdu_busy, 0);

        // redirect together with a start: both happen
        hif.id_redirect = 1'b1; hif.id_mdu_start = 1'b1;
        #1 chk("rs_flush", hif.if_id_flush, 1);
        chk("rs_start", hif.mdu_start, 1);
        tick();
        clear_inputs();

        // 5: lw $0 ; add using $0 -> no stall
        do_reset();
        hif.ex_mem2r = 1'b1; hif.ex_regw = 1'b1; hif.ex_rd = 5'd0; id_reads(5'd0, 5'd0);
        #1 chk("t5_r0", hif.pc_stall, 0);
        tick();

        // 5b: reset during BUSY cycle 3
        clear_inputs(); hif.ex_mem2r = 1'b1; hif.ex_rd = 5'd7; id_reads(5'd7, 5'd0);
        tick();
        clear_inputs(); hif.id_mdu_start = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        chk("t5_busy3", hif.mdu_busy, 1);
        rst = 1'b1; hif.id_mdu_read = 1'b1;
        #1 chk("t5_rst_busy", hif.mdu_busy, 0);
        chk("t5_rst_stall", hif.pc_stall, 0);
        chk("t5_rst_cnt", hif.stall_cnt, 0);
        tick();
        rst = 1'b0;
        #1 chk("t5_after_busy", hif.mdu_busy, 0);
        chk("t5_after_cnt", hif.stall_cnt, 0);
        chk("t5_after_stall", hif.pc_stall, 0);
        tick();

        // 6: stall counter saturation (CNT_W=4: 14 then +3 -> 15)
        do_reset();
        hif.ex_mem2r = 1'b1; hif.ex_rd = 5'd9; id_reads(5'd9, 5'd1);
        for (int i = 0; i < 14; i++) tick();
        chk("t6_near_max", hif.stall_cnt, 14);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_saturated", hif.stall_cnt, 15);
        clear_inputs();
        tick();
        chk("t6_hold", hif.stall_cnt, 15);
        tick();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
